// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared defaults and fill-state encoding for the FIFO     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fifo_pkg;

   localparam int c_data_width_def = 10;
   localparam int c_addr_width_def = 3;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } fill_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_mem : DEPTH x DATA_WIDTH dual-port RAM, sync write/async read  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width_def,
   parameter int ADDR_WIDTH = c_addr_width_def
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int c_depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

   // Contents are never reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_flow_ctrl : synchronous FIFO with occupancy, thresholds and    |
// |                  sticky overflow/underflow flags                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fifo_flow_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width_def,
   parameter int ADDR_WIDTH = c_addr_width_def
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH:0]   thr_af,
   input  logic [ADDR_WIDTH:0]   thr_ae,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  r_valid;
   logic                  r_ovf;
   logic                  r_unf;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push_acc;
   logic                  w_pop_acc;
   fill_state_t           r_state;
   fill_state_t           w_state_nxt;

   // A full FIFO still accepts a push when a pop frees a slot on the same edge.
   assign w_push_acc = push && (!w_full || pop);
   assign w_pop_acc  = pop && !w_empty;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_push_acc),
      .wr_addr (r_wr_ptr),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   always_comb begin
      w_count_nxt = r_count;
      if (w_push_acc && !w_pop_acc) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_push_acc && w_pop_acc) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: begin
            if (w_push_acc) begin
               w_state_nxt = (w_count_nxt == c_depth) ? FULL : PARTIAL;
            end
         end
         PARTIAL: begin
            if (w_count_nxt == c_depth) begin
               w_state_nxt = FULL;
            end else if (w_count_nxt == '0) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_pop_acc && !w_push_acc) begin
               w_state_nxt = (w_count_nxt == '0) ? EMPTY : PARTIAL;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= EMPTY;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_valid <= w_pop_acc;
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_acc) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= w_rd_data;
         end
         if (push && w_full && !pop) begin
            r_ovf <= 1'b1;
         end
         if (pop && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   assign w_full        = (r_state == FULL);
   assign w_empty       = (r_state == EMPTY);
   assign full          = w_full;
   assign empty         = w_empty;
   assign count         = r_count;
   assign data_out      = r_data_out;
   assign valid_out     = r_valid;
   assign overflow_err  = r_ovf;
   assign underflow_err = r_unf;
   assign almost_full   = (r_count >= thr_af);
   assign almost_empty  = (r_count <= thr_ae);

endmodule : fifo_flow_ctrl
`default_nettype wire

// File: tb/tb_fifo_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_flow_ctrl : directed self-checking bench for fifo_flow_ctrl |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fifo_flow_ctrl;

   logic       clk;
   logic       reset;
   logic       push;
   logic       pop;
   logic [9:0] data_in;
   logic [3:0] thr_af;
   logic [3:0] thr_ae;
   logic [9:0] data_out;
   logic       valid_out;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow_err;
   logic       underflow_err;

   int checks = 0;
   int errors = 0;

   fifo_flow_ctrl #(
      .DATA_WIDTH (10),
      .ADDR_WIDTH (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .push          (push),
      .pop           (pop),
      .data_in       (data_in),
      .thr_af        (thr_af),
      .thr_ae        (thr_ae),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, then settle just past the rising edge.
   task automatic tick(input logic p, input logic q, input logic [9:0] d);
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
   endtask

   initial begin
      reset   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
      thr_af  = 4'd6;
      thr_ae  = 4'd2;

      tick(1'b0, 1'b0, 10'h0);
      tick(1'b0, 1'b0, 10'h0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      chk("rst_unf", 32'(underflow_err), 32'd0);
      chk("rst_ae", 32'(almost_empty), 32'd1);
      chk("rst_af", 32'(almost_full), 32'd0);
      thr_af = 4'd0;
      #1;
      chk("af_thr0", 32'(almost_full), 32'd1);
      thr_af = 4'd6;
      #1;
      chk("af_thr6", 32'(almost_full), 32'd0);
      reset = 1'b1;

      // Fill
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0, 10'(32'h090 + i));
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
         chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
         chk("fill_full", 32'(full), 32'(i == 7));
         chk("fill_empty", 32'(empty), 32'd0);
      end

      // Drain
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, 10'h0);
         chk("drain_valid", 32'(valid_out), 32'd1);
         chk("drain_data", 32'(data_out), 32'h090 + 32'(i));
         chk("drain_count", 32'(count), 32'(7 - i));
         chk("drain_ae", 32'(almost_empty), 32'((7 - i) <= 2));
         chk("drain_full", 32'(full), 32'd0);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      tick(1'b0, 1'b0, 10'h0);
      chk("idle_valid", 32'(valid_out), 32'd0);
      chk("idle_hold", 32'(data_out), 32'h097);
      chk("drain_unf", 32'(underflow_err), 32'd0);

      // Overflow
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0, 10'(32'h0B0 + i));
      end
      chk("ovf_pre_full", 32'(full), 32'd1);
      chk("ovf_pre_flag", 32'(overflow_err), 32'd0);
      tick(1'b1, 1'b0, 10'h155);
      chk("ovf_flag", 32'(overflow_err), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_valid", 32'(valid_out), 32'd0);
      tick(1'b0, 1'b0, 10'h0);
      chk("ovf_sticky", 32'(overflow_err), 32'd1);

      // Simultaneous push/pop while full
      tick(1'b1, 1'b1, 10'h0AA);
      chk("fpp_data", 32'(data_out), 32'h0B0);
      chk("fpp_valid", 32'(valid_out), 32'd1);
      chk("fpp_count", 32'(count), 32'd8);
      chk("fpp_full", 32'(full), 32'd1);
      chk("fpp_unf", 32'(underflow_err), 32'd0);
      for (int i = 1; i < 9; i++) begin
         tick(1'b0, 1'b1, 10'h0);
         chk("fpp_drain_data", 32'(data_out), (i == 8) ? 32'h0AA : 32'h0B0 + 32'(i));
         chk("fpp_drain_count", 32'(count), 32'(8 - i));
      end
      chk("fpp_empty", 32'(empty), 32'd1);
      chk("fpp_unf_after", 32'(underflow_err), 32'd0);

      // Simultaneous push/pop while empty
      tick(1'b1, 1'b1, 10'h123);
      chk("epp_count", 32'(count), 32'd1);
      chk("epp_valid", 32'(valid_out), 32'd0);
      chk("epp_unf", 32'(underflow_err), 32'd1);
      chk("epp_empty", 32'(empty), 32'd0);
      tick(1'b0, 1'b0, 10'h0);
      chk("epp_unf_sticky", 32'(underflow_err), 32'd1);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 10'(32'h140 + i));
      end
      chk("mid_count", 32'(count), 32'd5);
      reset = 1'b0;
      tick(1'b0, 1'b0, 10'h0);
      reset = 1'b1;
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_empty", 32'(empty), 32'd1);
      chk("mrst_ovf", 32'(overflow_err), 32'd0);
      chk("mrst_unf", 32'(underflow_err), 32'd0);
      chk("mrst_data", 32'(data_out), 32'd0);
      chk("mrst_valid", 32'(valid_out), 32'd0);

      // Wrap-around with one word in flight
      tick(1'b1, 1'b0, 10'h200);
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, 1'b1, 10'(32'h201 + i));
         chk("wrap_data", 32'(data_out), 32'h200 + 32'(i));
         chk("wrap_valid", 32'(valid_out), 32'd1);
         chk("wrap_count", 32'(count), 32'd1);
      end
      tick(1'b0, 1'b1, 10'h0);
      chk("wrap_last", 32'(data_out), 32'h20C);
      chk("wrap_empty", 32'(empty), 32'd1);
      chk("wrap_unf", 32'(underflow_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_flow_ctrl
`default_nettype wire
